// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the single register-file write port (ALU vs load writeback).
// Latency: grant is combinational in the request cycle; the write appears on wr_* one cycle later.
// Backpressure: at most one ready per cycle, none under hold or reset; the output stage itself never stalls.
module regfile_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             r,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_rd,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_rd,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [AW-1:0]    wr_rd,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_en,
  output logic             last_grant
);

  // Round-robin pointer: 0 favours requester 0, 1 favours requester 1.
  logic             prio_q, prio_d;

  // Registered output stage feeding the register file write port.
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_rd_q, wr_rd_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  // Grant decode and selected write.
  logic             grant0, grant1, xfer;
  logic [AW-1:0]    sel_rd;
  logic [WIDTH-1:0] sel_data;

  // Grant decode: a lone requester wins outright, contention goes to the pointer holder.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!r && !hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_rd     = grant1 ? req1_rd   : req0_rd;
  assign sel_data   = grant1 ? req1_data : req0_data;

  // Next state: pointer flips away from the winner; x0 writes are consumed without enabling the write.
  always_comb begin
    prio_d    = prio_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      prio_d    = grant0;
      wr_en_d   = (sel_rd != '0);
      wr_rd_d   = sel_rd;
      wr_data_d = sel_data;
    end
  end

  // State update; reset wins over any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (r) begin
      prio_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  // A write sitting in the output stage when reset arrives is masked so the register file never captures it.
  assign wr_en      = wr_en_q & ~r;
  assign wr_rd      = wr_rd_q;
  assign wr_data    = wr_data_q;
  assign last_grant = ~prio_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the register-file write arbiter.
// Latency: compares grants in the request cycle and writes one cycle later against a reference model.
// Backpressure: requesters hold valid/rd/data stable until their handshake completes.
module tb_regfile_write_arbiter;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             r, hold;
  logic             req0_valid, req1_valid;
  logic [AW-1:0]    req0_rd, req1_rd;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [AW-1:0]    wr_rd;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en, last_grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .r(r), .hold(hold),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_rd(wr_rd), .wr_data(wr_data), .wr_en(wr_en), .last_grant(last_grant)
  );

  // Register file attached to the DUT write port (x0 hardwired to zero).
  logic             rf_clear;
  logic [WIDTH-1:0] rf [32];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en && wr_rd != '0) begin
      rf[wr_rd] <= wr_data;
    end
  end

  // Reference model state.
  int               mprio;
  bit               m_en;
  logic [AW-1:0]    m_rd;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] mrf [32];

  // Observations from the most recent cycle.
  logic hs0, hs1, o_rdy0, o_rdy1, o_wr_en, o_last;
  logic [AW-1:0]    o_wr_rd;
  logic [WIDTH-1:0] o_wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; compare against the model, then advance it at the edge.
  task automatic cycle();
    bit e0, e1;
    int winner;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!r && !hold) begin
      if (req0_valid && req1_valid) begin
        e0 = (mprio == 0);
        e1 = (mprio == 1);
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    o_rdy0 = req0_ready; o_rdy1 = req1_ready; o_wr_en = wr_en;
    o_wr_rd = wr_rd; o_wr_data = wr_data; o_last = last_grant;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("one_ready", req0_ready & req1_ready, 0);
    chk("wr_en", wr_en, m_en && !r);
    chk("wr_rd", wr_rd, m_rd);
    chk("wr_data", wr_data, m_data);
    chk("last_grant", last_grant, 1 - mprio);
    @(posedge clk);
    if (m_en && !r) mrf[m_rd] = m_data;
    if (r) begin
      m_en = 0; m_rd = '0; m_data = '0; mprio = 0;
    end else if (e0 || e1) begin
      winner = e1 ? 1 : 0;
      m_rd   = e1 ? req1_rd : req0_rd;
      m_data = e1 ? req1_data : req0_data;
      m_en   = (m_rd != 0);
      mprio  = 1 - winner;
    end else begin
      m_en = 0;
    end
    #1;
  endtask

  int issued, consumed, w0, w1, wen_cnt;

  initial begin
    r = 1'b1; hold = 1'b0; rf_clear = 1'b1;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    mprio = 0; m_en = 0; m_rd = '0; m_data = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rf_clear = 1'b0;

    // Reset state: a request presented during reset is not consumed.
    req0_valid = 1'b1; req0_rd = 5; req0_data = 32'hDEADBEEF;
    cycle();
    chk("rst_rdy0", o_rdy0, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_rd", o_wr_rd, 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_last", o_last, 1);

    // Single write.
    r = 1'b0;
    cycle();
    chk("t1_grant", hs0, 1);
    req0_valid = 1'b0;
    cycle();
    chk("t1_wr_en", o_wr_en, 1);
    chk("t1_wr_rd", o_wr_rd, 5);
    chk("t1_wr_data", o_wr_data, 32'hDEADBEEF);
    cycle();
    chk("t1_rf5", rf[5], 32'hDEADBEEF);

    // x0 write is consumed but never enabled.
    req1_valid = 1'b1; req1_rd = 0; req1_data = 32'hFFFFFFFF;
    cycle();
    chk("x0_grant", hs1, 1);
    req1_valid = 1'b0;
    cycle();
    chk("x0_wr_en", o_wr_en, 0);
    chk("x0_last", o_last, 1);
    chk("x0_rf0", rf[0], 0);

    // Contention: alternating grants starting with requester 0.
    req0_valid = 1'b1; req0_rd = 1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_rd = 2; req1_data = 32'h22;
    wen_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("ct_grant0", hs0, (k % 2) == 0);
      chk("ct_grant1", hs1, (k % 2) == 1);
      chk("ct_last", o_last, (k % 2) == 0);
      wen_cnt += int'(o_wr_en);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();
    wen_cnt += int'(o_wr_en);
    chk("ct_wen_cnt", wen_cnt, 4);

    // Move the pointer to requester 1, then collide on x7.
    req0_valid = 1'b1; req0_rd = 3; req0_data = 32'h33;
    cycle();
    req0_valid = 1'b0;
    cycle();
    req0_valid = 1'b1; req0_rd = 7; req0_data = 32'hAAAA;
    req1_valid = 1'b1; req1_rd = 7; req1_data = 32'hBBBB;
    cycle();
    chk("col_first1", hs1, 1);
    chk("col_first0", hs0, 0);
    req1_valid = 1'b0;
    cycle();
    chk("col_second", hs0, 1);
    chk("col_wdata1", o_wr_data, 32'hBBBB);
    req0_valid = 1'b0;
    cycle();
    chk("col_wdata0", o_wr_data, 32'hAAAA);
    cycle();
    chk("col_rf7", rf[7], 32'hAAAA);

    // Hold blocks grants; release grants in the same cycle; reset drops the pending write.
    hold = 1'b1;
    req0_valid = 1'b1; req0_rd = 9; req0_data = 32'h9999;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_rdy0", o_rdy0, 0);
      chk("hold_wr_en", o_wr_en, 0);
    end
    hold = 1'b0;
    cycle();
    chk("hold_release", hs0, 1);
    req0_valid = 1'b0;
    r = 1'b1;
    cycle();
    chk("rst_drop_wen", o_wr_en, 0);
    r = 1'b0;
    cycle();
    chk("rst_after_wen", o_wr_en, 0);
    chk("rst_after_last", o_last, 1);
    chk("rst_rf9", rf[9], 0);

    // Random stress.
    issued = 0; consumed = 0; w0 = 0; w1 = 0;
    for (int c = 0; c < 10000; c++) begin
      hold = ($urandom_range(7) == 0);
      if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1'b1; req0_rd = AW'($urandom_range(31)); req0_data = $urandom; issued++;
      end
      if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1'b1; req1_rd = AW'($urandom_range(31)); req1_data = $urandom; issued++;
        if ($urandom_range(3) == 0) req1_rd = req0_rd;
      end
      cycle();
      if (hs0) w0 = 0; else if (req0_valid && !hold) w0++;
      if (hs1) w1 = 0; else if (req1_valid && !hold) w1++;
      chk("wait0", w0 <= 1, 1);
      chk("wait1", w1 <= 1, 1);
      if (hs0) begin req0_valid = 1'b0; consumed++; end
      if (hs1) begin req1_valid = 1'b0; consumed++; end
    end
    hold = 1'b0;
    for (int k = 0; k < 4 && (req0_valid || req1_valid); k++) begin
      cycle();
      if (hs0) begin req0_valid = 1'b0; consumed++; end
      if (hs1) begin req1_valid = 1'b0; consumed++; end
    end
    chk("drain", req0_valid | req1_valid, 0);
    chk("accounting", consumed, issued);
    repeat (2) cycle();
    for (int i = 0; i < 32; i++) chk("rf_final", {27'd0, 5'(i), rf[i]}, {27'd0, 5'(i), mrf[i]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
